// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit RISC CPU: opcodes, sequencer phases, phase width.
// Pure constants plus one opcode-class helper; no logic state.
package cpu_pkg;
  localparam int PH_W = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [PH_W-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PH_W-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PH_W-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PH_W-1:0] PH_IDLE       = 3'd3;
  localparam logic [PH_W-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PH_W-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PH_W-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PH_W-1:0] PH_STORE      = 3'd7;

  // Instructions that read memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction
endpackage

// File: rtl/phase_counter.sv
// Wrapping phase counter; advances every cycle unless hold is high.
// One-cycle update, async clear to phase 0.
module phase_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  output logic [PH_W-1:0] phase
);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  always_comb begin
    phase_d = hold ? phase_q : phase_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: decodes phase/opcode/zero into datapath strobes.
// Strobes are combinational in the current phase; HLT freezes the sequence at phase 5 until reset.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic [2:0] phase
);

  logic halted_q;
  logic halted_d;
  logic aluop;

  // The counter steps 4->5 on the same edge that sets halted, so it parks at 5.
  phase_counter u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (halted_q),
    .phase (phase)
  );

  always_comb begin
    halted_d = halted_q | ((phase == PH_OP_ADDR) && (opcode == OP_HLT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign aluop = is_aluop(opcode);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        default: begin
          // PH_STORE; for JMP both PC strobes fire and ld_pc wins at the PC.
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          inc_pc = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the 8-bit RISC CPU. It advances a 3-bit phase counter once per clock and decodes phase, opcode and accumulator-zero into the strobes that drive the PC and ADD_Mux path, instruction register, memory and accumulator. It sits beside the datapath and is the sole source of PC increment, load and stop control. Each instruction takes exactly eight cycles. HLT freezes the sequence until reset.

## Interface
- No parameters. Opcode and phase encodings come from the shared package.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  3  instruction register opcode field. Stable from phase 3 onward.
- zero  in  1  accumulator == 0, from ALU/accumulator.
- sel  out  1  memory address mux: 1 = PC, 0 = IR operand address.
- rd  out  1  memory read enable.
- ld_ir  out  1  load instruction register.
- ld_ac  out  1  load accumulator.
- wr  out  1  memory write strobe.
- data_e  out  1  drive accumulator onto data bus.
- inc_pc  out  1  PC += 1 this cycle.
- ld_pc  out  1  PC <= IR operand address this cycle.
- halt  out  1  CPU halted; also drives PC `stop`.
- phase  out  3  current phase, for debug and bench.

## Operation
- State consists of the phase register (0..7) and a halted flag.
- The phase increments by 1 each cycle and wraps from 7 to 0. There is no stall input.
- ALUOP is true when opcode is ADD, AND, XOR or LDA.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Outputs are combinational from phase, opcode, zero and halted. Any output not listed for a phase is 0.
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc; halt = (opcode==HLT).
  - 5 OP_FETCH: rd = ALUOP.
  - 6 ALU_OP:
    - rd = ALUOP, ld_ac = ALUOP
    - inc_pc = (opcode==SKZ && zero)
    - ld_pc = JMP
    - data_e = STO
  - 7 STORE:
    - rd = ALUOP, ld_ac = ALUOP
    - ld_pc = JMP, inc_pc = JMP
    - wr = STO, data_e = STO
- Halt behaviour:
  - When phase==4 and opcode==HLT, the halted flag sets on the next edge.
  - While halted: the phase freezes at 5, halt=1, and all other strobes are 0 regardless of opcode or zero.
  - Only rst_n clears the halted flag.
- inc_pc and ld_pc are both 1 only in STORE for JMP. In that case ld_pc has priority at the PC.

## Timing
- Reset: asserting rst_n low immediately forces phase=0 and halted=0. This holds even mid-instruction; any partial instruction is abandoned.
  - Outputs while in reset: sel=1; rd, ld_ir, ld_ac, wr, data_e, inc_pc, ld_pc, halt = 0.
- The first rising edge after rst_n deasserts moves phase 0 to 1.
- Instruction latency is 8 cycles, from INST_ADDR to the next INST_ADDR.
- Ordering of effects:
  - The IR captures the instruction on the edge ending phase 3.
  - The PC increments on the edge ending phase 4.
  - The SKZ extra increment lands on the edge ending phase 6.
  - The accumulator loads on the edge ending phase 7.
- zero is sampled only during phase 6. Changes to zero in other phases have no effect.
- halt first asserts combinationally in phase 4. The halted flag registers at the end of phase 4 and stays high from phase 5 on.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams OP_HLT..OP_JMP
  - phase localparams PH_INST_ADDR..PH_STORE
  - a 3-bit width constant
- Sub-module `phase_counter`: 3-bit wrapping counter with async active-low clear and a hold input driven by halted.
- Decode lives in a single always @(*) block inside cpu_controller.

## Test plan
- Reset and free-run: hold rst_n=0 for 3 cycles, then release with opcode=ADD, zero=0.
  - Required: phase steps 0,1,...,7,0.
  - Required: sel=1 in phases 0–3; ld_ir=1 in phases 2–3; inc_pc=1 only in phase 4; ld_ac=1 in phases 6–7.
- SKZ, skip taken: opcode=SKZ, zero=1 → inc_pc=1 in phases 4 and 6.
- SKZ, skip not taken: opcode=SKZ, zero=0 → inc_pc=1 in phase 4 only, and rd=0 in phases 5–7.
- STO and JMP:
  - opcode=STO → data_e=1 in phases 6–7 and wr=1 in phase 7 only.
  - opcode=JMP → ld_pc=1 in phases 6–7 and inc_pc=1 in phases 4 and 7.
- Halt: opcode=HLT → halt=1 from phase 4 on; phase stays at 5 for 20 cycles with all strobes 0; pulse rst_n low → phase=0, halt=0.
- Reset mid-instruction: drop rst_n asynchronously in phase 6 with opcode=LDA.
  - Required: phase=0 and ld_ac=0 immediately, without waiting for a clock edge.
  - Required: after release, a clean 8-cycle sequence.
